// File: rtl/sector_cache_ctrl.sv
// sector_cache_ctrl: sectored set-associative tag/state model with true-LRU; define WRITEBACK_EN for dirty tracking
module sector_cache_ctrl #(
  parameter int CACHE_SIZE    = 8192,
  parameter int LINE_SIZE     = 32,
  parameter int SECTOR_SIZE   = 8,
  parameter int ASSOCIATIVITY = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int FILL_LATENCY  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic                  resp_sector_miss,
  output logic [31:0]           total_hits,
  output logic [31:0]           total_misses,
  output logic [31:0]           sector_misses,
  output logic [31:0]           writebacks
);
  localparam int SPL      = LINE_SIZE / SECTOR_SIZE;
  localparam int NUM_SETS = CACHE_SIZE / LINE_SIZE / ASSOCIATIVITY;
  localparam int OFF_W    = $clog2(SECTOR_SIZE);
  localparam int SEC_W    = $clog2(SPL);
  localparam int SET_W    = $clog2(NUM_SETS);
  localparam int LINE_W   = $clog2(LINE_SIZE);
  localparam int TAG_BITS = ADDR_WIDTH - SET_W - LINE_W;
  localparam int WAY_W    = $clog2(ASSOCIATIVITY);
  localparam int CNT_W    = $clog2(FILL_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

  state_t state, next_state;

  logic [TAG_BITS-1:0]      tags      [NUM_SETS][ASSOCIATIVITY];
  logic [ASSOCIATIVITY-1:0] valid     [NUM_SETS];
  logic [SPL-1:0]           sec_valid [NUM_SETS][ASSOCIATIVITY];
  logic [WAY_W-1:0]         age       [NUM_SETS][ASSOCIATIVITY];

  logic [TAG_BITS-1:0] tag_q;
  logic [SET_W-1:0]    set_q;
  logic [SEC_W-1:0]    sec_q;
  logic [WAY_W-1:0]    way_q;
  logic                line_miss_q;
  logic [CNT_W-1:0]    cnt;

  logic             match_any, sec_hit, hit, inv_found, accept, fill_done, lru_upd;
  logic [WAY_W-1:0] hit_way, inv_way, age0_way, victim, tgt_way, acc_way, acc_age;
  logic [SPL-1:0]   sec_onehot;
  logic             unused_bits;

  assign accept     = req_valid && req_ready;
  assign fill_done  = state == FILL && cnt == CNT_W'(FILL_LATENCY - 1);
  assign hit        = match_any && sec_hit;
  assign lru_upd    = (state == LOOKUP && hit) || fill_done;
  assign acc_way    = state == LOOKUP ? hit_way : way_q;
  assign acc_age    = age[set_q][acc_way];
  assign sec_onehot = SPL'(1) << sec_q;

`ifdef WRITEBACK_EN
  logic [SPL-1:0] dirty [NUM_SETS][ASSOCIATIVITY];
  logic           write_q;
  assign unused_bits = ^req_addr[OFF_W-1:0];
`else
  assign unused_bits = ^{req_write, req_addr[OFF_W-1:0]};
  assign writebacks  = '0;
`endif

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return v + 32'(en && v != 32'hFFFF_FFFF);
  endfunction

  // Tag compare across the set, plus victim choice: first invalid way, else the LRU way
  always_comb begin
    match_any = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    age0_way  = '0;
    for (int i = 0; i < ASSOCIATIVITY; i++) begin
      if (valid[set_q][i] && tags[set_q][i] == tag_q) begin
        match_any = 1'b1;
        hit_way   = WAY_W'(i);
      end
      if (!valid[set_q][i] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(i);
      end
      if (age[set_q][i] == '0) age0_way = WAY_W'(i);
    end
    victim  = inv_found ? inv_way : age0_way;
    sec_hit = sec_valid[set_q][hit_way][sec_q];
    tgt_way = match_any ? hit_way : victim;
  end

  // State register
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = accept ? LOOKUP : IDLE;
      LOOKUP:  next_state = hit ? RESP : FILL;
      FILL:    next_state = fill_done ? RESP : FILL;
      default: next_state = IDLE;
    endcase
  end

  // Handshake, request capture, response flags and performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready        <= 1'b0;
      resp_valid       <= 1'b0;
      resp_hit         <= 1'b0;
      resp_sector_miss <= 1'b0;
      cnt              <= '0;
      tag_q            <= '0;
      set_q            <= '0;
      sec_q            <= '0;
      way_q            <= '0;
      line_miss_q      <= 1'b0;
      total_hits       <= '0;
      total_misses     <= '0;
      sector_misses    <= '0;
`ifdef WRITEBACK_EN
      write_q          <= 1'b0;
      writebacks       <= '0;
`endif
    end else begin
      req_ready  <= next_state == IDLE;
      resp_valid <= state == RESP;
      cnt        <= state == FILL ? cnt + 1'b1 : '0;
      if (accept) begin
        tag_q <= req_addr[ADDR_WIDTH-1 -: TAG_BITS];
        set_q <= req_addr[LINE_W +: SET_W];
        sec_q <= req_addr[OFF_W +: SEC_W];
`ifdef WRITEBACK_EN
        write_q <= req_write;
`endif
      end
      if (state == LOOKUP) begin
        resp_hit         <= hit;
        resp_sector_miss <= match_any && !sec_hit;
        way_q            <= tgt_way;
        line_miss_q      <= !match_any;
        total_hits       <= sat_inc(total_hits, hit);
        total_misses     <= sat_inc(total_misses, !hit);
        sector_misses    <= sat_inc(sector_misses, match_any && !sec_hit);
`ifdef WRITEBACK_EN
        writebacks       <= sat_inc(writebacks, !match_any && valid[set_q][victim] && |dirty[set_q][victim]);
`endif
      end
    end
  end

  // Tags carry no reset: a tag is only looked at while its way is valid
  always_ff @(posedge clk) begin
    if (!rst && fill_done && line_miss_q) tags[set_q][way_q] <= tag_q;
  end

  // Line/sector valid, dirty and LRU age state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
          sec_valid[s][w] <= '0;
          age[s][w]       <= WAY_W'(w);
`ifdef WRITEBACK_EN
          dirty[s][w]     <= '0;
`endif
        end
      end
    end else begin
      if (lru_upd)
        for (int i = 0; i < ASSOCIATIVITY; i++)
          age[set_q][i] <= WAY_W'(i) == acc_way ? WAY_W'(ASSOCIATIVITY - 1) :
                           age[set_q][i] > acc_age ? age[set_q][i] - 1'b1 : age[set_q][i];
      if (fill_done && line_miss_q) begin
        valid[set_q][way_q]     <= 1'b1;
        sec_valid[set_q][way_q] <= sec_onehot;
`ifdef WRITEBACK_EN
        dirty[set_q][way_q]     <= write_q ? sec_onehot : '0;
`endif
      end else if (fill_done) begin
        sec_valid[set_q][way_q][sec_q] <= 1'b1;
`ifdef WRITEBACK_EN
        if (write_q) dirty[set_q][way_q][sec_q] <= 1'b1;
`endif
      end
`ifdef WRITEBACK_EN
      if (state == LOOKUP && hit && write_q) dirty[set_q][hit_way][sec_q] <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_sector_cache_ctrl.sv
// tb_sector_cache_ctrl: directed scoreboard bench for sector_cache_ctrl
module tb_sector_cache_ctrl;
  localparam int FILL_LATENCY = 4;
  localparam int HIT_LAT = 2;
  localparam int MISS_LAT = 2 + FILL_LATENCY;
`ifdef WRITEBACK_EN
  localparam int WB_EXP = 1;
`else
  localparam int WB_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready, resp_valid, resp_hit, resp_sector_miss;
  logic [31:0] total_hits, total_misses, sector_misses, writebacks;

  sector_cache_ctrl #(.FILL_LATENCY(FILL_LATENCY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .resp_sector_miss(resp_sector_miss),
    .total_hits(total_hits), .total_misses(total_misses),
    .sector_misses(sector_misses), .writebacks(writebacks)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    bit    hit;
    bit    smiss;
    int    acc;
    int    lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expected entry
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: resp_valid at cycle %0d with nothing outstanding", cyc);
      end else begin
        cur = sb.pop_front();
        check({cur.name, "_hit"}, 32'(resp_hit), 32'(cur.hit));
        check({cur.name, "_smiss"}, 32'(resp_sector_miss), 32'(cur.smiss));
        check({cur.name, "_latency"}, 32'(cyc - cur.acc), 32'(cur.lat));
      end
    end
  end

  task automatic issue(input string name, input logic [31:0] a, input bit w,
                       input bit h, input bit sm, input bit track);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_ready_timeout: req_ready stayed low for %0d cycles", name, n);
      return;
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = ~a;
    req_write = ~w;
    if (track) sb.push_back('{name, h, sm, cyc, h ? HIT_LAT : MISS_LAT});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_resp_timeout: %0d responses outstanding", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_ctrs(input string name, input int h, input int m, input int s, input int wb);
    check({name, "_total_hits"}, total_hits, 32'(h));
    check({name, "_total_misses"}, total_misses, 32'(m));
    check({name, "_sector_misses"}, sector_misses, 32'(s));
    check({name, "_writebacks"}, writebacks, 32'(wb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_hit", 32'(resp_hit), 32'd0);
    check("reset_resp_smiss", 32'(resp_sector_miss), 32'd0);
    check_ctrs("reset", 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(req_ready), 32'd1);

    issue("ld0000_cold", 32'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done("ld0000_cold");
    check_ctrs("after_cold", 0, 1, 0, 0);
    issue("ld0000_hit", 32'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_done("ld0000_hit");
    check_ctrs("after_hit", 1, 1, 0, 0);
    issue("ld0008_smiss", 32'h0008, 1'b0, 1'b0, 1'b1, 1'b1);
    issue("ld0008_hit", 32'h0008, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_done("ld0008");
    check_ctrs("after_sector", 2, 2, 1, 0);

    issue("ld0800", 32'h0800, 1'b0, 1'b0, 1'b0, 1'b1);
    issue("ld1000", 32'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
    issue("ld1800", 32'h1800, 1'b0, 1'b0, 1'b0, 1'b1);
    issue("ld2000_evict", 32'h2000, 1'b0, 1'b0, 1'b0, 1'b1);
    issue("ld0000_evicted", 32'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    issue("ld1000_still", 32'h1000, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_done("eviction");
    check_ctrs("after_evict", 3, 7, 1, 0);

    issue("st0020", 32'h0020, 1'b1, 1'b0, 1'b0, 1'b1);
    issue("ld0820", 32'h0820, 1'b0, 1'b0, 1'b0, 1'b1);
    issue("ld1020", 32'h1020, 1'b0, 1'b0, 1'b0, 1'b1);
    issue("ld1820", 32'h1820, 1'b0, 1'b0, 1'b0, 1'b1);
    issue("ld2020_wb", 32'h2020, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done("writeback");
    check_ctrs("after_wb", 3, 12, 1, WB_EXP);

    issue("abort3000", 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check_ctrs("abort_reset", 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    check_ctrs("abort_quiet", 0, 0, 0, 0);
    issue("ld0000_after_abort", 32'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done("after_abort");
    check_ctrs("after_abort", 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
